// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the mem_arb memory-bus arbiter.
// Source IDs tag each accepted request so responses can be routed back in order.
package mem_arb_pkg;

  typedef enum logic {
    SRC_IM = 1'b0,
    SRC_DM = 1'b1
  } src_e;

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_HOLD = 1'b1
  } lock_e;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Winner among the two ports; pref breaks the tie when both are valid.
  function automatic src_e pick_src(input logic dm_valid, input logic im_valid, input src_e pref);
    src_e win;
    if (dm_valid && im_valid) begin
      win = pref;
    end else if (dm_valid) begin
      win = SRC_DM;
    end else if (im_valid) begin
      win = SRC_IM;
    end else begin
      win = pref;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// DEPTH-deep, 1-bit synchronous FIFO holding the source ID of each outstanding request.
// A push at full is honoured only when a pop happens in the same cycle.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = cnt_w(DEPTH),
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          head
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == LAST_PTR) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1'b1);
    end
    return n;
  endfunction

  assign do_pop  = pop && (cnt != {CW{1'b0}});
  assign do_push = push && ((cnt != FULL_CNT) || do_pop);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  // Storage and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= {DEPTH{1'b0}};
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= {CW{1'b0}};
    end else begin
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1'b1);
        2'b01:   cnt <= cnt - CW'(1'b1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbiter for one memory bus shared by instruction fetch (im_*) and load/store (dm_*).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise DM has fixed priority.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUT = 2,
  parameter int AW      = 64,
  parameter int DW      = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   im_req_addr,
  input  logic            im_req_valid,
  output logic            im_req_ready,
  output logic [DW-1:0]   im_resp_rdata,
  output logic            im_resp_valid,
  input  logic [AW-1:0]   dm_req_addr,
  input  logic [DW-1:0]   dm_req_wdata,
  input  logic [DW/8-1:0] dm_req_wmask,
  input  logic            dm_req_wen,
  input  logic            dm_req_valid,
  output logic            dm_req_ready,
  output logic [DW-1:0]   dm_resp_rdata,
  output logic            dm_resp_valid,
  output logic [AW-1:0]   bus_req_addr,
  output logic [DW-1:0]   bus_req_wdata,
  output logic [DW/8-1:0] bus_req_wmask,
  output logic            bus_req_wen,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  input  logic [DW-1:0]   bus_resp_rdata,
  input  logic            bus_resp_valid,
  output logic            arb_err
);

  localparam int CW = cnt_w(MAX_OUT);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

  lock_e         state;
  lock_e         state_nxt;
  src_e          lock_src;
  src_e          lock_src_nxt;
  src_e          grant;
  src_e          pref;
  logic          sel_valid;
  logic          full_blk;
  logic          accept;
  logic          id_pop;
  logic          id_empty;
  logic          id_head;
  logic [CW-1:0] id_count;

`ifdef MEM_ARB_RR_EN
  src_e rr_ptr;

  assign pref = rr_ptr;

  // Round-robin pointer hands the next tie to the port that just lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= SRC_DM;
    end else if (accept) begin
      rr_ptr <= (grant == SRC_DM) ? SRC_IM : SRC_DM;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
`else
  assign pref = SRC_DM;
`endif

  // A stalled request keeps its grant until the bus takes it.
  always_comb begin
    if (state == ST_HOLD) begin
      grant = lock_src;
    end else begin
      grant = pick_src(dm_req_valid, im_req_valid, pref);
    end
  end

  assign sel_valid     = (grant == SRC_DM) ? dm_req_valid : im_req_valid;
  // A response beat frees a slot in the same cycle, so it lifts the full condition.
  assign full_blk      = (id_count == FULL_CNT) && !bus_resp_valid;
  assign bus_req_valid = sel_valid && !full_blk;
  assign accept        = bus_req_valid && bus_req_ready;
  assign im_req_ready  = accept && (grant == SRC_IM);
  assign dm_req_ready  = accept && (grant == SRC_DM);

  // Request mux; fetches carry no write data or mask.
  always_comb begin
    bus_req_addr  = {AW{1'b0}};
    bus_req_wdata = {DW{1'b0}};
    bus_req_wmask = {(DW/8){1'b0}};
    bus_req_wen   = 1'b0;
    if (bus_req_valid) begin
      case (grant)
        SRC_DM: begin
          bus_req_addr  = dm_req_addr;
          bus_req_wdata = dm_req_wdata;
          bus_req_wmask = dm_req_wmask;
          bus_req_wen   = dm_req_wen;
        end
        SRC_IM: begin
          bus_req_addr  = im_req_addr;
        end
        default: begin
          bus_req_addr  = {AW{1'b0}};
        end
      endcase
    end else begin
      bus_req_wen   = 1'b0;
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_OPEN;
      lock_src <= SRC_IM;
    end else begin
      state    <= state_nxt;
      lock_src <= lock_src_nxt;
    end
  end

  // Lock next-state: set on an unaccepted request, release on accept.
  always_comb begin
    state_nxt    = state;
    lock_src_nxt = lock_src;
    case (state)
      ST_OPEN: begin
        if (bus_req_valid && !bus_req_ready) begin
          state_nxt    = ST_HOLD;
          lock_src_nxt = grant;
        end else begin
          state_nxt    = ST_OPEN;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          state_nxt = ST_OPEN;
        end else begin
          state_nxt = ST_HOLD;
        end
      end
      default: begin
        state_nxt    = ST_OPEN;
        lock_src_nxt = SRC_IM;
      end
    endcase
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (grant),
    .pop   (id_pop),
    .count (id_count),
    .head  (id_head)
  );

  assign id_empty      = (id_count == {CW{1'b0}});
  assign id_pop        = bus_resp_valid && !id_empty;
  assign im_resp_valid = id_pop && (id_head == SRC_IM);
  assign dm_resp_valid = id_pop && (id_head == SRC_DM);
  assign im_resp_rdata = bus_resp_rdata;
  assign dm_resp_rdata = bus_resp_rdata;

  // Sticky error: a response beat with nothing outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_err <= 1'b0;
    end else if (bus_resp_valid && id_empty) begin
      arb_err <= 1'b1;
    end else begin
      arb_err <= arb_err;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed, scoreboard-based bench for mem_arb (MAX_OUT=2, AW=DW=64).
// Expected source IDs are queued at request time and checked when response beats return.
module tb_mem_arb;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] im_req_addr;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [63:0] im_resp_rdata;
  logic        im_resp_valid;
  logic [63:0] dm_req_addr;
  logic [63:0] dm_req_wdata;
  logic [7:0]  dm_req_wmask;
  logic        dm_req_wen;
  logic        dm_req_valid;
  logic        dm_req_ready;
  logic [63:0] dm_resp_rdata;
  logic        dm_resp_valid;
  logic [63:0] bus_req_addr;
  logic [63:0] bus_req_wdata;
  logic [7:0]  bus_req_wmask;
  logic        bus_req_wen;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_resp_rdata;
  logic        bus_resp_valid;
  logic        arb_err;

  int   checks = 0;
  int   errors = 0;
  src_e exp_q[$];

  mem_arb #(.MAX_OUT(2), .AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .im_req_addr(im_req_addr), .im_req_valid(im_req_valid), .im_req_ready(im_req_ready),
    .im_resp_rdata(im_resp_rdata), .im_resp_valid(im_resp_valid),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask),
    .dm_req_wen(dm_req_wen), .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
    .bus_req_wen(bus_req_wen), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_resp_rdata(bus_resp_rdata), .bus_resp_valid(bus_resp_valid), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    im_req_addr    = 64'h0;
    im_req_valid   = 1'b0;
    dm_req_addr    = 64'h0;
    dm_req_wdata   = 64'h0;
    dm_req_wmask   = 8'h0;
    dm_req_wen     = 1'b0;
    dm_req_valid   = 1'b0;
    bus_req_ready  = 1'b0;
    bus_resp_rdata = 64'h0;
    bus_resp_valid = 1'b0;
  endtask

  // Checks the response routing for a beat the bench is currently driving.
  task automatic resp_check(input string tag);
    src_e s;
    if (exp_q.size() == 0) begin
      check({tag, "_im_rv"}, {63'h0, im_resp_valid}, 64'h0);
      check({tag, "_dm_rv"}, {63'h0, dm_resp_valid}, 64'h0);
    end else begin
      s = exp_q.pop_front();
      check({tag, "_im_rv"}, {63'h0, im_resp_valid}, {63'h0, (s == SRC_IM)});
      check({tag, "_dm_rv"}, {63'h0, dm_resp_valid}, {63'h0, (s == SRC_DM)});
      check({tag, "_rdata"}, (s == SRC_IM) ? im_resp_rdata : dm_resp_rdata, bus_resp_rdata);
    end
  endtask

  // Checks handshake outcome; an expected accept is pushed onto the scoreboard.
  task automatic req_check(input string tag, input bit acc, input src_e s,
                           input logic [63:0] addr, input bit wen);
    check({tag, "_im_rdy"}, {63'h0, im_req_ready}, {63'h0, (acc && s == SRC_IM)});
    check({tag, "_dm_rdy"}, {63'h0, dm_req_ready}, {63'h0, (acc && s == SRC_DM)});
    if (acc) begin
      check({tag, "_addr"}, bus_req_addr, addr);
      check({tag, "_wen"}, {63'h0, bus_req_wen}, {63'h0, wen});
      exp_q.push_back(s);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      bus_resp_valid = 1'b1;
      bus_resp_rdata = 64'hA000 + 64'(i);
      #2;
      resp_check("drain");
      tick();
      bus_resp_valid = 1'b0;
    end
  endtask

  initial begin
    int n;
    src_e s;
    rst = 1'b0;
    idle();
    #12;
    // Reset state
    check("rst_bus_valid", {63'h0, bus_req_valid}, 64'h0);
    check("rst_im_rv", {63'h0, im_resp_valid}, 64'h0);
    check("rst_dm_rv", {63'h0, dm_resp_valid}, 64'h0);
    check("rst_err", {63'h0, arb_err}, 64'h0);
    check("rst_addr", bus_req_addr, 64'h0);
    tick();
    rst = 1'b1;
    tick();

    // 1: fetch only, response two cycles later
    im_req_valid = 1'b1; im_req_addr = 64'h100; bus_req_ready = 1'b1;
    dm_req_wdata = 64'hFFFF; dm_req_wmask = 8'hFF;
    #2;
    req_check("t1_req", 1'b1, SRC_IM, 64'h100, 1'b0);
    check("t1_wdata", bus_req_wdata, 64'h0);
    check("t1_wmask", {56'h0, bus_req_wmask}, 64'h0);
    tick();
    idle();
    tick();
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'h1234;
    #2;
    resp_check("t1_resp");
    check("t1_rdata", im_resp_rdata, 64'h1234);
    tick();
    idle();

    // 2: simultaneous requests, DM first then IM
    im_req_valid = 1'b1; im_req_addr = 64'h200;
    dm_req_valid = 1'b1; dm_req_addr = 64'h300; dm_req_wen = 1'b1;
    dm_req_wdata = 64'hDEAD; dm_req_wmask = 8'hF0; bus_req_ready = 1'b1;
    #2;
    req_check("t2_first", 1'b1, SRC_DM, 64'h300, 1'b1);
    check("t2_wdata", bus_req_wdata, 64'hDEAD);
    check("t2_wmask", {56'h0, bus_req_wmask}, 64'hF0);
    tick();
    dm_req_valid = 1'b0;
    #2;
    req_check("t2_second", 1'b1, SRC_IM, 64'h200, 1'b0);
    tick();
    idle();
    drain(2);

    // 3: stalled IM keeps the grant when DM rises
    im_req_valid = 1'b1; im_req_addr = 64'h440; bus_req_ready = 1'b0;
    #2;
    check("t3_c1_valid", {63'h0, bus_req_valid}, 64'h1);
    req_check("t3_c1", 1'b0, SRC_IM, 64'h0, 1'b0);
    tick();
    for (int c = 2; c <= 3; c++) begin
      dm_req_valid = 1'b1; dm_req_addr = 64'h550;
      #2;
      check("t3_hold_addr", bus_req_addr, 64'h440);
      check("t3_hold_valid", {63'h0, bus_req_valid}, 64'h1);
      req_check("t3_hold", 1'b0, SRC_IM, 64'h0, 1'b0);
      tick();
    end
    bus_req_ready = 1'b1;
    #2;
    req_check("t3_accept", 1'b1, SRC_IM, 64'h440, 1'b0);
    tick();
    im_req_valid = 1'b0;
    #2;
    req_check("t3_dm", 1'b1, SRC_DM, 64'h550, 1'b0);
    tick();
    idle();
    drain(2);

    // 4: outstanding limit and same-cycle pop/push at full
    bus_req_ready = 1'b1; im_req_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      im_req_addr = 64'h400 + 64'(8 * k);
      #2;
      req_check("t4_fill", 1'b1, SRC_IM, im_req_addr, 1'b0);
      tick();
    end
    im_req_addr = 64'h410;
    #2;
    check("t4_full_valid", {63'h0, bus_req_valid}, 64'h0);
    req_check("t4_full", 1'b0, SRC_IM, 64'h0, 1'b0);
    tick();
    im_req_valid = 1'b0; dm_req_valid = 1'b1; dm_req_addr = 64'h500;
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'h4444;
    #2;
    resp_check("t4_pop");
    req_check("t4_push", 1'b1, SRC_DM, 64'h500, 1'b0);
    tick();
    dm_req_valid = 1'b0; bus_resp_valid = 1'b0;
    im_req_valid = 1'b1; im_req_addr = 64'h418;
    #2;
    req_check("t4_still_full", 1'b0, SRC_IM, 64'h0, 1'b0);
    tick();
    idle();
    drain(2);

    // 5: stray response sets the sticky error
    check("t5_err_before", {63'h0, arb_err}, 64'h0);
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'h5555;
    #2;
    resp_check("t5_stray");
    tick();
    idle();
    check("t5_err_set", {63'h0, arb_err}, 64'h1);
    tick();
    tick();
    check("t5_err_sticky", {63'h0, arb_err}, 64'h1);
    rst = 1'b0;
    #1;
    check("t5_err_clear", {63'h0, arb_err}, 64'h0);
    tick();
    rst = 1'b1;
    tick();

    // 6: both ports valid continuously; responses keep the FIFO from filling
    for (int i = 0; i < 6; i++) begin
      im_req_valid = 1'b1; im_req_addr = 64'h6000 + 64'(i);
      dm_req_valid = 1'b1; dm_req_addr = 64'h7000 + 64'(i);
      bus_req_ready = 1'b1;
      bus_resp_valid = (exp_q.size() != 0);
      bus_resp_rdata = 64'hB0 + 64'(i);
      #2;
      if (bus_resp_valid) begin
        resp_check("t6_resp");
      end
`ifdef MEM_ARB_RR_EN
      s = (i % 2 == 0) ? SRC_DM : SRC_IM;
`else
      s = SRC_DM;
`endif
      req_check("t6_order", 1'b1, s, (s == SRC_DM) ? dm_req_addr : im_req_addr, 1'b0);
      tick();
    end
    idle();
    n = exp_q.size();
    drain(n);
    check("t6_err", {63'h0, arb_err}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
